// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the configuration latch loader.
//   state_t   : loader sequencing states
//   ROW_W     : row address width for the default 16-row array
//   onehot()  : row index to one-hot row select (callers truncate to their width)
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        GATE  = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int NUM_ROWS_DEF = 16;
    localparam int ROW_W        = $clog2(NUM_ROWS_DEF);
    localparam int MAX_ROWS     = 256;

    // Returns a wide one-hot; each instance size-casts it down to NUM_ROWS.
    function automatic logic [MAX_ROWS-1:0] onehot(input logic [7:0] row);
        logic [MAX_ROWS-1:0] v;
        v      = '0;
        v[row] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cfg_frame_buf.sv
// Frame buffer: FRAME_WORDS x WORD_W register written one word at a time.
//   clk, rst_n : clock, async active-low reset (clears the buffer)
//   we_i       : write enable
//   idx_i      : word index to write (word 0 = LSBs of data_o)
//   wdata_i    : word to write
//   data_o     : whole frame, drives the latch D bus
import cfg_loader_pkg::*;

module cfg_frame_buf #(
    parameter int WORD_W      = 32,
    parameter int FRAME_WORDS = 8,
    parameter int IDX_W       = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we_i,
    input  logic [IDX_W-1:0]              idx_i,
    input  logic [WORD_W-1:0]             wdata_i,
    output logic [WORD_W*FRAME_WORDS-1:0] data_o
);

    logic [WORD_W*FRAME_WORDS-1:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (we_i) begin
            for (int w = 0; w < FRAME_WORDS; w++) begin
                if (idx_i == IDX_W'(w)) begin
                    frame_q[w*WORD_W +: WORD_W] <= wdata_i;
                end
            end
        end
    end

    assign data_o = frame_q;

endmodule

// File: rtl/cfg_latch_loader.sv
// Configuration latch loader: collects a frame of words from a valid/ready
// stream, then presents it to one row of level-sensitive latches with a
// setup / gate / hold sequence on the latch gate.
//   C, R        : clock (rising edge), async active-low reset
//   start       : begin a frame load (IDLE only), row_addr captured with it
//   abort       : synchronous abort of the frame in flight
//   in_valid/in_ready/in_data : word stream
//   frame_data  : latch D bus, row_sel : one-hot row, latch_g : latch gate
//   busy, done, err : status (done/err are one-cycle pulses)
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting frame words
// SETUP | data and row_sel stable, gate low
// GATE  | latch gate high
// HOLD  | gate low, row_sel still held
// DONE  | done pulse, row_sel released
import cfg_loader_pkg::*;

module cfg_latch_loader #(
    parameter int WORD_W      = 32,
    parameter int FRAME_WORDS = 8,
    parameter int NUM_ROWS    = 16,
    parameter int SETUP_CYC   = 1,
    parameter int GATE_CYC    = 2
) (
    input  logic                          C,
    input  logic                          R,
    input  logic                          start,
    input  logic [$clog2(NUM_ROWS)-1:0]   row_addr,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             in_data,
    output logic [WORD_W*FRAME_WORDS-1:0] frame_data,
    output logic [NUM_ROWS-1:0]           row_sel,
    output logic                          latch_g,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int ROW_AW   = $clog2(NUM_ROWS);
    localparam int IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int MAX_CYC  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [ROW_AW-1:0]   row_q, row_d;
    logic [NUM_ROWS-1:0] row_sel_q, row_sel_d;
    logic                latch_g_q, latch_g_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_en;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        row_d      = row_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (32'(row_addr) < NUM_ROWS) begin
                            state_d    = LOAD;
                            word_cnt_d = '0;
                            row_d      = row_addr;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        wr_en      = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == LAST_IDX) begin
                            state_d   = SETUP;
                            cyc_cnt_d = CNT_W'(SETUP_CYC - 1);
                        end
                    end
                end
                SETUP: begin
                    if (cyc_cnt_q == '0) begin
                        state_d   = GATE;
                        cyc_cnt_d = CNT_W'(GATE_CYC - 1);
                    end else begin
                        cyc_cnt_d = cyc_cnt_q - 1'b1;
                    end
                end
                GATE: begin
                    if (cyc_cnt_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q - 1'b1;
                    end
                end
                HOLD:    state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register in step
        // with the state they belong to.
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        latch_g_d  = (state_d == GATE);
        done_d     = (state_d == DONE);
        if (state_d == SETUP || state_d == GATE || state_d == HOLD) begin
            row_sel_d = NUM_ROWS'(onehot(8'(row_d)));
        end else begin
            row_sel_d = '0;
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            row_q      <= '0;
            row_sel_q  <= '0;
            latch_g_q  <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            row_q      <= row_d;
            row_sel_q  <= row_sel_d;
            latch_g_q  <= latch_g_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    cfg_frame_buf #(
        .WORD_W      (WORD_W),
        .FRAME_WORDS (FRAME_WORDS),
        .IDX_W       (IDX_W)
    ) u_frame_buf (
        .clk     (C),
        .rst_n   (R),
        .we_i    (wr_en),
        .idx_i   (word_cnt_q),
        .wdata_i (in_data),
        .data_o  (frame_data)
    );

    assign row_sel  = row_sel_q;
    assign latch_g  = latch_g_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cfg_latch_loader.sv
module tb_cfg_latch_loader;

    localparam int WW  = 32;
    localparam int FW  = 4;
    localparam int NR  = 16;
    localparam int S   = 1;
    localparam int G   = 2;
    localparam int NR2 = 12;

    logic C = 1'b0;
    logic R = 1'b0;
    always #5 C = ~C;

    logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [3:0]    row_addr = '0;
    logic [WW-1:0] in_data = '0;
    logic          in_ready, latch_g, busy, done, err;
    logic [127:0]  frame_data;
    logic [15:0]   row_sel;

    logic          start2 = 1'b0, abort2 = 1'b0, in_valid2 = 1'b0;
    logic [3:0]    row2 = '0;
    logic [WW-1:0] in_data2 = '0;
    logic          in_ready2, latch_g2, busy2, done2, err2;
    logic [127:0]  frame2;
    logic [11:0]   row_sel2;

    cfg_latch_loader #(.WORD_W(WW), .FRAME_WORDS(FW), .NUM_ROWS(NR),
                       .SETUP_CYC(S), .GATE_CYC(G)) dut (
        .C(C), .R(R), .start(start), .row_addr(row_addr), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .frame_data(frame_data), .row_sel(row_sel), .latch_g(latch_g),
        .busy(busy), .done(done), .err(err));

    cfg_latch_loader #(.WORD_W(WW), .FRAME_WORDS(FW), .NUM_ROWS(NR2),
                       .SETUP_CYC(S), .GATE_CYC(G)) dut2 (
        .C(C), .R(R), .start(start2), .row_addr(row2), .abort(abort2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .frame_data(frame2), .row_sel(row_sel2), .latch_g(latch_g2),
        .busy(busy2), .done(done2), .err(err2));

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: timeline of a frame. mode 0 = idle, 1 = collecting words,
    // 2 = sequencing, k = cycles elapsed since the last-word handshake.
    int            mode, cnt, k;
    logic [3:0]    m_row;
    logic [WW-1:0] m_w [FW];
    logic          m_err;

    always @(posedge C or negedge R) begin
        if (!R) begin
            mode = 0; cnt = 0; k = 0; m_row = '0; m_err = 1'b0;
            for (int i = 0; i < FW; i++) m_w[i] = '0;
        end else begin
            m_err = 1'b0;
            if (mode == 0) begin
                if (start && !abort) begin
                    if (int'(row_addr) < NR) begin
                        mode = 1; cnt = 0; m_row = row_addr;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (mode == 1) begin
                if (abort) mode = 0;
                else if (in_valid) begin
                    m_w[cnt] = in_data;
                    cnt++;
                    if (cnt == FW) begin mode = 2; k = 1; end
                end
            end else begin
                if (abort || k == S + G + 2) mode = 0;
                else k++;
            end
        end
    end

    logic [15:0]  e_rs;
    logic [127:0] e_fr;
    always @(negedge C) begin
        if (R && run_chk) begin
            e_rs = (mode == 2 && k <= S + G + 1) ? (16'd1 << m_row) : 16'd0;
            e_fr = {m_w[3], m_w[2], m_w[1], m_w[0]};
            chk("m_busy",     busy,       mode != 0);
            chk("m_in_ready", in_ready,   mode == 1);
            chk("m_row_sel",  row_sel,    e_rs);
            chk("m_latch_g",  latch_g,    mode == 2 && k > S && k <= S + G);
            chk("m_done",     done,       mode == 2 && k == S + G + 2);
            chk("m_err",      err,        m_err);
            chk("m_frame",    frame_data, e_fr);
        end
    end

    logic [WW-1:0] wv [FW];

    task automatic tick();
        @(negedge C);
    endtask

    // Called at a negedge with the DUT idle; returns at cycle +1 after the
    // last-word handshake.
    task automatic load_frame(input logic [3:0] row, input int gap, input bit stray);
        start = 1'b1; row_addr = row;
        tick();
        start = 1'b0;
        for (int i = 0; i < FW; i++) begin
            if (i > 0) begin
                for (int j = 0; j < gap; j++) begin
                    in_valid = 1'b0;
                    if (stray && j == 0) begin start = 1'b1; row_addr = 4'd7; end
                    tick();
                    start = 1'b0;
                    chk("gap_in_ready", in_ready, 1'b1);
                end
            end
            in_valid = 1'b1; in_data = wv[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pin_seq(input logic [15:0] rs, input logic [127:0] fr);
        chk("p_frame",  frame_data, fr);
        chk("p_rs_su",  row_sel, rs);
        chk("p_g_su",   latch_g, 1'b0);
        chk("p_rdy_su", in_ready, 1'b0);
        tick(); chk("p_g_c2", latch_g, 1'b1); chk("p_rs_c2", row_sel, rs);
        tick(); chk("p_g_c3", latch_g, 1'b1);
        tick(); chk("p_g_hold", latch_g, 1'b0); chk("p_rs_hold", row_sel, rs);
        tick(); chk("p_done", done, 1'b1); chk("p_rs_done", row_sel, 16'h0);
                chk("p_busy_done", busy, 1'b1);
        tick(); chk("p_busy_end", busy, 1'b0); chk("p_done_end", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy",  in_ready, 1'b0);
        chk("rst_rs",   row_sel, 16'h0);
        chk("rst_frame", frame_data, 128'h0);
        R = 1'b1; run_chk = 1'b1;
        repeat (2) tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_rdy",  in_ready, 1'b0);
        chk("idle_g",    latch_g, 1'b0);

        wv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        load_frame(4'd5, 0, 1'b0);
        pin_seq(16'h0020, 128'h44444444_33333333_22222222_11111111);

        load_frame(4'd5, 3, 1'b1);
        pin_seq(16'h0020, 128'h44444444_33333333_22222222_11111111);

        wv = '{32'hA5A5A5A5, 32'h0000FFFF, 32'hDEADBEEF, 32'h01234567};
        load_frame(4'd15, 1, 1'b0);
        pin_seq(16'h8000, 128'h01234567_DEADBEEF_0000FFFF_A5A5A5A5);

        for (int r = 12; r <= 13; r++) begin
            start2 = 1'b1; row2 = 4'(r);
            tick();
            start2 = 1'b0;
            chk("d2_err",  err2, 1'b1);
            chk("d2_busy", busy2, 1'b0);
            tick();
            chk("d2_err_end", err2, 1'b0);
            chk("d2_g",       latch_g2, 1'b0);
            chk("d2_busy2",   busy2, 1'b0);
        end
        start2 = 1'b1; row2 = 4'd11;
        tick();
        start2 = 1'b0;
        chk("d2_ok_busy", busy2, 1'b1);
        chk("d2_ok_err",  err2, 1'b0);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("d2_abort_busy", busy2, 1'b0);

        start = 1'b1; abort = 1'b1; row_addr = 4'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1'b0);

        wv = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        load_frame(4'd3, 0, 1'b0);
        tick();
        chk("ab_g_before", latch_g, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_g",     latch_g, 1'b0);
        chk("ab_rs",    row_sel, 16'h0);
        chk("ab_busy",  busy, 1'b0);
        chk("ab_frame", frame_data, 128'h00000004_00000003_00000002_00000001);
        repeat (3) begin tick(); chk("ab_nodone", done, 1'b0); end
        wv = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        load_frame(4'd9, 0, 1'b0);
        pin_seq(16'h0200, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);

        start = 1'b1; row_addr = 4'd2;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h77777777;
        tick();
        in_data = 32'h88888888;
        tick();
        in_valid = 1'b0;
        chk("mid_rdy", in_ready, 1'b1);
        #2 R = 1'b0;
        #1;
        chk("ar_busy",  busy, 1'b0);
        chk("ar_rdy",   in_ready, 1'b0);
        chk("ar_frame", frame_data, 128'h0);
        chk("ar_rs",    row_sel, 16'h0);
        chk("ar_g",     latch_g, 1'b0);
        tick();
        R = 1'b1;
        tick();
        wv = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040};
        load_frame(4'd0, 0, 1'b0);
        pin_seq(16'h0001, 128'h40404040_30303030_20202020_10101010);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
